// File: rtl/serial_twos_complement.sv
// rtl/serial_twos_complement.sv - bit-serial LSB-first two's-complement negator with overflow flag
module serial_twos_complement #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             seen_one;
    logic             ovf;

    logic bit_in;
    logic bit_out;
    logic last_bit;

    // Bits up to and including the first 1 pass through; every later bit is inverted.
    assign bit_in   = sr[0];
    assign bit_out  = seen_one ? ~bit_in : bit_in;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = result;
    assign out_ovf   = ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, WIDTH shift cycles, hold in DONE until consumed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch word on accept, then emit one negated bit per clock into result MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr       <= '0;
            result   <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= in_data;
                        cnt      <= '0;
                        seen_one <= 1'b0;
                    end
                end
                SHIFT: begin
                    result   <= {bit_out, result[WIDTH-1:1]};
                    sr       <= sr >> 1;
                    seen_one <= seen_one | bit_in;
                    cnt      <= cnt + CNT_W'(1);
                    // Only the most-negative word reaches its MSB with no earlier 1 and a 1 there.
                    if (last_bit) begin
                        ovf <= ~seen_one & bit_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_twos_complement.md
Name: serial_twos_complement

Overview:
- Bit-serial two's-complement negator for WIDTH-bit words.
- Sequential counterpart to the combinational 5-bit complement chain: it feeds the Guia_08 arithmetic datapath one word at a time over a valid/ready handshake.
- Uses the "copy bits up to and including the first 1, invert every bit above it" rule, processing LSB-first, one bit per clock.
- Flags the single non-negatable value (most-negative number).

Parameters:
- WIDTH, 5, word width in bits; must be ≥ 2.
- CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data holds a word to negate.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to negate (two's-complement).
- out_valid  output  1  out_data/out_ovf hold a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  -in_data modulo 2^WIDTH.
- out_ovf  output  1  1 when in_data was 1 followed by WIDTH-1 zeros (negation overflow).
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Interface: one clock, clk; reset rst_n, synchronous, active-low. Sampled only on the rising edge of clk. There is no asynchronous path.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - Shift register, result register, counter, seen_one and ovf are cleared.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0.
- Reset during SHIFT or DONE aborts the word; no result is emitted.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On an edge with in_valid=1: latch in_data into the shift register, set cnt=0, set seen_one=0, go to SHIFT.
  - SHIFT:
    - in_ready=0. Each edge:
      - b = sr[0].
      - r = seen_one ? ~b : b.
      - result <= {r, result[WIDTH-1:1]}.
      - sr <= sr >> 1.
      - seen_one <= seen_one | b.
      - cnt <= cnt + 1.
    - At the edge where cnt == WIDTH-1 (the MSB is processed): ovf <= (~seen_one & b), then go to DONE.
  - DONE:
    - out_valid=1, in_ready=0.
    - out_data and out_ovf are held stable until out_ready=1 at an edge; then go to IDLE.
- Latency: the accept edge, plus WIDTH SHIFT edges. out_valid rises after the WIDTH-th edge following accept.
- Throughput: at most one word per WIDTH+2 cycles. There is no overlap and no bypass.
- out_valid rises in the cycle after the DONE entry edge.
- in_ready is registered-state-decoded: high only in IDLE. A new word cannot be accepted in the same cycle a result is consumed; it is accepted at the next IDLE edge.
- out_data holds its last value after consumption. It is not cleared; it is valid only while out_valid=1.
- Arithmetic is modulo 2^WIDTH:
  - Zero input gives 0 with ovf=0.
  - Most-negative input gives itself with ovf=1.
  - All other inputs give the exact negation with ovf=0.
- in_valid while not in IDLE is ignored; in_data is not re-sampled.
- Back-pressure: out_ready=0 in DONE stalls indefinitely with no state change.

Test Plan:
- Reset, then in_data=5'b00111 with in_valid pulsed in IDLE:
  - in_ready drops the next cycle.
  - out_valid rises exactly 5 edges after accept with out_data=5'b11001, out_ovf=0.
- in_data=5'b00000 gives out_data=5'b00000, out_ovf=0.
- in_data=5'b11111 gives out_data=5'b00001, out_ovf=0.
- in_data=5'b10000 gives out_data=5'b10000, out_ovf=1.
- Back-pressure: hold out_ready=0 for 4 cycles in DONE.
  - out_valid and out_data stay constant, and in_ready stays 0 with in_valid held high.
  - Raise out_ready: in_ready=1 the next cycle, and the held word is accepted there.
- Assert rst_n=0 for one edge after 2 SHIFT cycles:
  - Next cycle in_ready=1, out_valid=0, out_data=0, busy=0, and no result ever appears.
  - A following word 5'b00001 yields 5'b11111.
